// File: rtl/control_ram_write_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : control_ram_write_arbiter_pkg                                    |
// | Shared framebuffer address types, defaults and a width helper used by the  |
// | RAM write-port arbiter and its round-robin picker.                         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package control_ram_write_arbiter_pkg;

   localparam int DEFAULT_BYTES_PER_PIXEL = 2;

   // Framebuffer address field widths (640x480, 2 bytes per pixel fits in 20 bits)
   localparam int ROW_W   = 9;
   localparam int COL_W   = 10;
   localparam int PIXEL_W = 20;

   typedef logic [ROW_W-1:0]   row_addr_t;
   typedef logic [COL_W-1:0]   col_addr_t;
   typedef logic [PIXEL_W-1:0] pixel_addr_t;

   // Bits needed to index 'value' distinct items; never less than 1 so a
   // degenerate count still yields a legal vector width.
   function automatic int safe_bits(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage
`default_nettype wire

// File: rtl/control_ram_write_arbiter_rr_priority_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : control_ram_write_arbiter_rr_priority_pick                       |
// | Combinational round-robin picker: first set request bit at or after ptr,   |
// | wrapping modulo NUM_REQ.                                                   |
// | Ports   : req (request vector), ptr (search start index),                  |
// |           pick_onehot / pick_idx (winner), pick_valid (any request)        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module control_ram_write_arbiter_rr_priority_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick_onehot,
   output logic [IDX_W-1:0]   pick_idx,
   output logic               pick_valid
);

   int               slot;
   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      pick_onehot = '0;
      pick_idx    = '0;
      found       = 1'b0;
      slot        = 0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         slot = int'(ptr) + k;
         if (slot >= NUM_REQ) begin
            slot = slot - NUM_REQ;
         end
         cand = IDX_W'(slot);
         if (!found && req[cand]) begin
            found             = 1'b1;
            pick_onehot[cand] = 1'b1;
            pick_idx          = cand;
         end
      end
   end

   assign pick_valid = |req;

endmodule
`default_nettype wire

// File: rtl/control_ram_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : control_ram_write_arbiter                                        |
// | Shares the framebuffer RAM write port between NUM_REQ command engines.     |
// | Round-robin grant, held for a whole command (done pulse / req drop /       |
// | optional hold timeout), followed by one hold-off cycle.                    |
// | Ports   : clk, reset (sync, active-high)                                   |
// |           req, release_i, req_row/column/pixel/data/we/access_start (per   |
// |           requester, flattened, requester 0 in the LSBs)                   |
// |           grant, row, column, pixel, data_out, ram_write_enable,           |
// |           ram_access_start (all registered), busy, timeout_err (sticky)    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module control_ram_write_arbiter
   import control_ram_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int BYTES_PER_PIXEL = DEFAULT_BYTES_PER_PIXEL,
   parameter int HOLD_TIMEOUT    = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         release_i,
   input  logic [NUM_REQ*ROW_W-1:0]   req_row,
   input  logic [NUM_REQ*COL_W-1:0]   req_column,
   input  logic [NUM_REQ*PIXEL_W-1:0] req_pixel,
   input  logic [NUM_REQ*8-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_we,
   input  logic [NUM_REQ-1:0]         req_access_start,
   output logic [NUM_REQ-1:0]         grant,
   output logic [ROW_W-1:0]           row,
   output logic [COL_W-1:0]           column,
   output logic [PIXEL_W-1:0]         pixel,
   output logic [7:0]                 data_out,
   output logic                       ram_write_enable,
   output logic                       ram_access_start,
   output logic                       busy,
   output logic                       timeout_err
);

   localparam int IDX_W    = safe_bits(NUM_REQ);
   localparam int TMR_W    = safe_bits(HOLD_TIMEOUT + 1);
   localparam int TMR_LAST = (HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0;
   localparam logic [TMR_W-1:0] TMR_LAST_C = TMR_W'(TMR_LAST);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REQ - 1);

   // Requester index width depends on NUM_REQ, so the type lives here
   typedef logic [IDX_W-1:0] arb_req_idx_t;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANTED = 2'd1,
      ARB_HOLDOFF = 2'd2
   } arb_state_e;

   if ((NUM_REQ < 2) || (NUM_REQ > 8) || (BYTES_PER_PIXEL < 1)) begin : g_bad_params
      $error("control_ram_write_arbiter: NUM_REQ must be 2..8 and BYTES_PER_PIXEL >= 1");
   end

   arb_state_e   state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   arb_req_idx_t owner_q, owner_d;
   arb_req_idx_t ptr_q, ptr_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic         err_q, err_d;
   row_addr_t    row_q, row_d;
   col_addr_t    col_q, col_d;
   pixel_addr_t  pixel_q, pixel_d;
   logic [7:0]   data_q, data_d;
   logic         we_q, we_d;
   logic         as_q, as_d;

   row_addr_t    row_arr   [NUM_REQ];
   col_addr_t    col_arr   [NUM_REQ];
   pixel_addr_t  pixel_arr [NUM_REQ];
   logic [7:0]   data_arr  [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign row_arr[i]   = req_row[i*ROW_W +: ROW_W];
      assign col_arr[i]   = req_column[i*COL_W +: COL_W];
      assign pixel_arr[i] = req_pixel[i*PIXEL_W +: PIXEL_W];
      assign data_arr[i]  = req_data[i*8 +: 8];
   end

   logic [NUM_REQ-1:0] pick_onehot;
   arb_req_idx_t       pick_idx;
   logic               pick_valid;

   control_ram_write_arbiter_rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req         (req),
      .ptr         (ptr_q),
      .pick_onehot (pick_onehot),
      .pick_idx    (pick_idx),
      .pick_valid  (pick_valid)
   );

   logic own_release, own_drop, timer_hit, own_exit;

   // timer_q counts owned cycles already completed, so the hit fires on the
   // HOLD_TIMEOUT-th owned cycle and the grant is held exactly that long.
   assign own_release = release_i[owner_q];
   assign own_drop    = ~req[owner_q];
   assign timer_hit   = (HOLD_TIMEOUT != 0) && (timer_q >= TMR_LAST_C);
   assign own_exit    = own_release | own_drop | timer_hit;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      timer_d = timer_q;
      err_d   = err_q;
      row_d   = '0;
      col_d   = '0;
      pixel_d = '0;
      data_d  = '0;
      we_d    = 1'b0;
      as_d    = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d = ARB_GRANTED;
               grant_d = pick_onehot;
               owner_d = pick_idx;
               timer_d = '0;
            end
         end
         ARB_GRANTED: begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
            // A done pulse coinciding with the last write still forwards that
            // write; a req drop or timeout exit cuts the port immediately.
            if (!own_exit || own_release) begin
               row_d   = row_arr[owner_q];
               col_d   = col_arr[owner_q];
               pixel_d = pixel_arr[owner_q];
               data_d  = data_arr[owner_q];
               we_d    = req_we[owner_q];
               as_d    = req_access_start[owner_q];
            end
            if (own_exit) begin
               state_d = ARB_HOLDOFF;
               grant_d = '0;
               ptr_d   = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
               if (timer_hit && !own_release && !own_drop) begin
                  err_d = 1'b1;
               end
            end
         end
         ARB_HOLDOFF: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         timer_q <= '0;
         err_q   <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
         pixel_q <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         as_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         timer_q <= timer_d;
         err_q   <= err_d;
         row_q   <= row_d;
         col_q   <= col_d;
         pixel_q <= pixel_d;
         data_q  <= data_d;
         we_q    <= we_d;
         as_q    <= as_d;
      end
   end

   assign grant            = grant_q;
   assign row              = row_q;
   assign column           = col_q;
   assign pixel            = pixel_q;
   assign data_out         = data_q;
   assign ram_write_enable = we_q;
   assign ram_access_start = as_q;
   assign busy             = (state_q != ARB_IDLE);
   assign timeout_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_control_ram_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_control_ram_write_arbiter                                     |
// | Scoreboard bench: behavioural requesters plus an ownership model push      |
// | expected port state and writes; a monitor pops and compares each cycle.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_control_ram_write_arbiter;
   import control_ram_write_arbiter_pkg::*;

   localparam int NREQ   = 4;
   localparam int HOLD_T = 8;
   localparam int CYCLES = 3000;

   logic clk = 1'b0;
   logic reset;
   logic [NREQ-1:0] req, release_i, req_we, req_access_start;
   row_addr_t   e_row  [NREQ];
   col_addr_t   e_col  [NREQ];
   pixel_addr_t e_pix  [NREQ];
   logic [7:0]  e_data [NREQ];
   logic [NREQ*ROW_W-1:0]   req_row;
   logic [NREQ*COL_W-1:0]   req_column;
   logic [NREQ*PIXEL_W-1:0] req_pixel;
   logic [NREQ*8-1:0]       req_data;

   logic [NREQ-1:0] grant;
   row_addr_t   row;
   col_addr_t   column;
   pixel_addr_t pixel;
   logic [7:0]  data_out;
   logic        ram_write_enable, ram_access_start, busy, timeout_err;

   assign req_row    = {e_row[3], e_row[2], e_row[1], e_row[0]};
   assign req_column = {e_col[3], e_col[2], e_col[1], e_col[0]};
   assign req_pixel  = {e_pix[3], e_pix[2], e_pix[1], e_pix[0]};
   assign req_data   = {e_data[3], e_data[2], e_data[1], e_data[0]};

   control_ram_write_arbiter #(
      .NUM_REQ         (NREQ),
      .BYTES_PER_PIXEL (2),
      .HOLD_TIMEOUT    (HOLD_T)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .req              (req),
      .release_i        (release_i),
      .req_row          (req_row),
      .req_column       (req_column),
      .req_pixel        (req_pixel),
      .req_data         (req_data),
      .req_we           (req_we),
      .req_access_start (req_access_start),
      .grant            (grant),
      .row              (row),
      .column           (column),
      .pixel            (pixel),
      .data_out         (data_out),
      .ram_write_enable (ram_write_enable),
      .ram_access_start (ram_access_start),
      .busy             (busy),
      .timeout_err      (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NREQ-1:0] grant;
      logic            we;
      logic            busy;
      logic            err;
   } status_t;

   typedef struct packed {
      row_addr_t   row;
      col_addr_t   col;
      pixel_addr_t pix;
      logic [7:0]  data;
      logic        as;
   } wr_t;

   status_t sq[$];
   wr_t     wq[$];
   int vectors    = 0;
   int miscompares = 0;

   // Requester engines: 0 idle, 1 waiting for grant, 2 owning
   int e_state [NREQ];
   int e_mode  [NREQ];   // 0 release with last write, 1 release after, 2 drop req, 3 never finish
   int e_left  [NREQ];

   // Ownership model: who should own the port in the current cycle
   int m_owner;          // -1 when nobody owns
   int m_held;           // owned cycles already completed
   int m_ptr;
   bit m_holdoff;
   bit m_err;

   task automatic drive_cycle(input int cyc);
      logic [NREQ-1:0] g;
      bit wr, rel, drop, to, fwd;
      int p_req, o, held;
      status_t e;
      g = grant;
      reset = (cyc < 3) || (cyc >= 100 && $urandom_range(249) == 0);
      p_req = (cyc < 100) ? 100 : 30;
      for (int i = 0; i < NREQ; i++) begin
         release_i[i]        = 1'b0;
         req_we[i]           = 1'b0;
         req_access_start[i] = 1'b0;
         e_row[i]  = row_addr_t'($urandom);
         e_col[i]  = col_addr_t'($urandom);
         e_pix[i]  = pixel_addr_t'($urandom);
         e_data[i] = 8'($urandom);
         if (cyc < 40 && i == 2) begin
            e_row[i]  = row_addr_t'(5);
            e_col[i]  = col_addr_t'(17);
            e_data[i] = 8'hA5;
         end
         wr = 1'b0;
         if (e_state[i] == 0) begin
            req[i] = 1'b0;
            if (cyc >= 3 && ((cyc < 40) ? (i == 2) : ($urandom_range(99) < p_req))) begin
               req[i]     = 1'b1;
               e_state[i] = 1;
               e_mode[i]  = (cyc < 100) ? 0 : int'($urandom_range(3));
               e_left[i]  = (cyc < 40) ? 1 : (cyc < 100) ? 3 : int'($urandom_range(5, 1));
            end else if (cyc >= 40) begin
               release_i[i] = ($urandom_range(7) == 0);
               req_we[i]    = ($urandom_range(3) == 0);
            end
         end
         if (e_state[i] == 1) begin
            if (g[i] === 1'b1) e_state[i] = 2;
            else if (cyc >= 40) req_we[i] = ($urandom_range(3) == 0);
         end
         if (e_state[i] == 2) begin
            if (g[i] !== 1'b1) begin
               req[i]     = 1'b0;
               e_state[i] = 0;
            end else begin
               case (e_mode[i])
                  0: if (e_left[i] > 0 && $urandom_range(3) != 0) begin
                        wr = 1'b1;
                        e_left[i]--;
                        if (e_left[i] == 0) release_i[i] = 1'b1;
                     end
                  1: if (e_left[i] > 0) begin
                        if ($urandom_range(3) != 0) begin wr = 1'b1; e_left[i]--; end
                     end else if (e_left[i] == 0) begin
                        release_i[i] = 1'b1;
                        e_left[i]    = -1;
                     end
                  2: if (e_left[i] > 0) begin
                        if ($urandom_range(3) != 0) begin wr = 1'b1; e_left[i]--; end
                     end else begin
                        req[i]    = 1'b0;
                        e_left[i] = -1;
                     end
                  default: wr = ($urandom_range(3) != 0);
               endcase
               req_we[i]           = wr;
               req_access_start[i] = wr;
            end
         end
      end

      // Reference: what the port must show one clock after these inputs
      fwd = 1'b0;
      o   = m_owner;
      if (m_owner >= 0) begin
         held = m_held + 1;
         rel  = release_i[o];
         drop = !req[o];
         to   = (held >= HOLD_T);
         fwd  = rel || !(drop || to);
         if (rel || drop || to) begin
            if (to && !rel && !drop) m_err = 1'b1;
            m_ptr     = (o + 1) % NREQ;
            m_owner   = -1;
            m_holdoff = 1'b1;
         end else begin
            m_held = held;
         end
      end else if (m_holdoff) begin
         m_holdoff = 1'b0;
      end else if (req != '0) begin
         for (int k = 0; k < NREQ; k++) begin
            int j = (m_ptr + k) % NREQ;
            if (m_owner < 0 && req[j]) begin
               m_owner = j;
               m_held  = 0;
            end
         end
      end
      if (reset) begin
         m_owner   = -1;
         m_holdoff = 1'b0;
         m_ptr     = 0;
         m_err     = 1'b0;
         fwd       = 1'b0;
      end
      e.grant = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
      e.we    = fwd ? req_we[o] : 1'b0;
      e.busy  = (m_owner >= 0) || m_holdoff;
      e.err   = m_err;
      sq.push_back(e);
      if (e.we) wq.push_back({e_row[o], e_col[o], e_pix[o], e_data[o], req_access_start[o]});
   endtask

   // Monitor: one status entry per clock, plus the payload whenever a write is due
   initial begin
      status_t exp_s, act_s;
      wr_t     exp_w, act_w;
      forever begin
         @(posedge clk);
         #3;
         if (sq.size() > 0) begin
            exp_s = sq.pop_front();
            act_s = {grant, ram_write_enable, busy, timeout_err};
            vectors++;
            if (act_s !== exp_s) begin
               miscompares++;
               $display("FAIL status t=%0t got grant=%b we=%b busy=%b err=%b, expected grant=%b we=%b busy=%b err=%b",
                        $time, act_s.grant, act_s.we, act_s.busy, act_s.err,
                        exp_s.grant, exp_s.we, exp_s.busy, exp_s.err);
            end
            if (exp_s.we && wq.size() > 0) begin
               exp_w = wq.pop_front();
               act_w = {row, column, pixel, data_out, ram_access_start};
               vectors++;
               if (act_w !== exp_w) begin
                  miscompares++;
                  $display("FAIL write t=%0t got row=%0d col=%0d pix=%h data=%h as=%b, expected row=%0d col=%0d pix=%h data=%h as=%b",
                           $time, act_w.row, act_w.col, act_w.pix, act_w.data, act_w.as,
                           exp_w.row, exp_w.col, exp_w.pix, exp_w.data, exp_w.as);
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         e_state[i] = 0;
         e_mode[i]  = 0;
         e_left[i]  = 0;
      end
      m_owner   = -1;
      m_held    = 0;
      m_ptr     = 0;
      m_holdoff = 1'b0;
      m_err     = 1'b0;
      drive_cycle(0);
      for (int cyc = 1; cyc < CYCLES; cyc++) begin
         @(posedge clk);
         #1;
         drive_cycle(cyc);
      end
      repeat (3) @(posedge clk);
      #5;
      vectors++;
      if (sq.size() != 0 || wq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d status and %0d writes left, expected 0 and 0", sq.size(), wq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
